// File: rtl/lshift_seq.sv
`default_nettype none
// lshift_seq: multi-cycle 16-bit left shifter/rotator, one barrel stage
// (1, 2, 4, 8) per clock, with valid/ready handshakes on both sides.
module lshift_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic             Rot_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_stage;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rot;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_next;

  // Stage s moves the word by 2^s; rotate refills the LSBs with the bits pushed out.
  always_comb begin
    w_shl = r_data;
    w_rol = r_data;
    case (r_stage)
      2'd0: begin
        w_shl = {r_data[14:0], 1'b0};
        w_rol = {r_data[14:0], r_data[15]};
      end
      2'd1: begin
        w_shl = {r_data[13:0], 2'b00};
        w_rol = {r_data[13:0], r_data[15:14]};
      end
      2'd2: begin
        w_shl = {r_data[11:0], 4'h0};
        w_rol = {r_data[11:0], r_data[15:12]};
      end
      default: begin
        w_shl = {r_data[7:0], 8'h00};
        w_rol = {r_data[7:0], r_data[15:8]};
      end
    endcase
  end

  assign w_next = r_cnt[r_stage] ? (r_rot ? w_rol : w_shl) : r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_stage     <= 2'd0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_rot       <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data  <= In;
            r_cnt   <= Cnt;
            r_rot   <= Rot_sel;
            r_stage <= 2'd0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_data  <= w_next;
          r_stage <= r_stage + 2'd1;
          if (r_stage == 2'd3) begin
            r_out       <= w_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Pure state decodes: no combinational path from out_ready to in_ready.
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_SHIFT);
  assign out_valid = r_out_valid;
  assign Out       = r_out;

endmodule
`default_nettype wire

// File: doc/lshift_seq.md
Name: lshift_seq

Overview:
- Multi-cycle 16-bit left shifter/rotator for the execute stage.
- Counterpart of the combinational right shifter/rotator; together they cover SLL/ROL alongside SRL/ROR.
- Implements a 4-stage logarithmic barrel (1, 2, 4, 8), evaluating one stage per clock. Stage select bits are held in a register.
- Valid/ready handshake on both the operand side and the result side, so the pipeline can stall it.

Parameters:
WIDTH, 16, datapath width. Must be 16; CNT_W is fixed at 4.
CNT_W, 4, shift-count width; equals the number of stages.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand presented
in_ready  out  1  block can accept an operand
In  in  16  data to shift/rotate
Cnt  in  4  shift amount, 0..15
Rot_sel  in  1  1 = rotate left, 0 = logical shift left (zero fill)
out_valid  out  1  Out holds a finished result
out_ready  in  1  consumer accepts the result
Out  out  16  result register
busy  out  1  high in SHIFT state

Behaviour:
- Reset is sampled on the rising clk edge with rst_n=0. It forces:
  - state=IDLE, stage counter=0
  - Out=0x0000, out_valid=0, busy=0, in_ready=1
  - internal data/cnt/rot registers=0
- Reset wins over every other event, including mid-SHIFT and in DONE with out_ready=1. Any in-flight operation is discarded with no output.
- FSM states:
  - IDLE: in_ready=1.
    - in_valid=1 at an edge: capture In into data_r, Cnt into cnt_r, Rot_sel into rot_r; stage=0; go SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT: busy=1, in_ready=0. Each edge applies stage s (s=0..3) to data_r, then increments s.
    - cnt_r[s]=0: data_r unchanged.
    - cnt_r[s]=1 and rot_r=0: data_r = data_r << 2^s, vacated LSBs zero.
    - cnt_r[s]=1 and rot_r=1: data_r = {data_r[15-2^s:0], data_r[15:16-2^s]}.
    - On the edge applying s=3: Out<=final value, out_valid<=1, go DONE.
  - DONE: out_valid=1, in_ready=0, Out stable.
    - out_ready=1 at an edge: out_valid<=0, go IDLE.
    - Otherwise hold Out and out_valid indefinitely (backpressure).
- Latency: accept at edge k; Out/out_valid valid after edge k+4. Latency is fixed at 4 regardless of Cnt, including Cnt=0.
- Throughput: one operation per 6 cycles minimum. There is no accept in DONE; in_ready is a pure state decode with no combinational path from out_ready.
- Inputs In/Cnt/Rot_sel/in_valid are ignored outside IDLE. Changing them mid-operation has no effect on the result.
- Out retains the last result after returning to IDLE until the next DONE load or reset.
- All arithmetic is modulo 16 bits; no carry/overflow outputs. Cnt=0 returns In unchanged for both modes.
- The stage counter is 2 bits and wraps from 3 to 0 only on the SHIFT->DONE transition.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> Out=0x0000, out_valid=0, in_ready=1, busy=0.
- Shift vs rotate, out_ready=1:
  - In=0x8001, Cnt=1, Rot_sel=0 -> Out=0x0002 after 4 cycles.
  - Same with Rot_sel=1 -> Out=0x0003.
  - In=0x1234, Cnt=4, Rot_sel=1 -> 0x2341.
- Boundaries:
  - In=0x0001, Cnt=15, shift -> 0x8000.
  - In=0x0003, Cnt=15, rotate -> 0x8001.
  - In=0xBEEF, Cnt=0 -> 0xBEEF, still exactly 4-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles after DONE.
  - Out and out_valid stay constant; in_ready=0; a new in_valid is not accepted.
  - Raise out_ready -> IDLE the next cycle.
- Input disturbance: accept In=0x00F0, Cnt=8, shift, then drive In=0xFFFF, Cnt=1 during SHIFT -> Out=0xF000.
- Reset mid-operation: assert rst_n=0 during stage 2 -> the next cycle is IDLE, Out=0x0000, out_valid never pulses. A fresh operation afterwards completes normally.
